pixel_write_master: RTL
=======================

PIXEL_WRITE_MASTER -- requirements
Module: pixel_write_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning Avalon address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning pixel colour / writedata width; legal values 16 or 32.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning pixel FIFO entries; power of two, minimum 2.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_valid  input  1  drawing engine presents a pixel.
REQ-007 pix_addr  input  ADDR_W  pixel byte address.
REQ-008 pix_color  input  DATA_W  pixel colour.
REQ-009 pix_ready  output  1  FIFO can accept a pixel this cycle.
REQ-010 wr_done  output  1  one-cycle pulse per completed Avalon write.
REQ-011 idle  output  1  FIFO empty and no write outstanding.
REQ-012 master_waitrequest  input  1  Avalon slave stall.
REQ-013 master_address  output  ADDR_W  Avalon address.
REQ-014 master_write  output  1  Avalon write strobe.
REQ-015 master_writedata  output  DATA_W  Avalon write data.
REQ-016 master_byteenable  output  DATA_W/8  constant all ones.

Function
REQ-017 Pixel SHALL be accepted on a rising edge where pix_valid and pix_ready are both high; pix_ready SHALL equal "FIFO not full", independent of pix_valid.
REQ-018 Accepted {pix_addr, pix_color} SHALL be stored in FIFO order; no reordering, dropping or duplication.
REQ-019 Output stage SHALL be a register {master_address, master_writedata, master_write} with two states: EMPTY (master_write=0) and FULL (master_write=1).
REQ-020 Output register SHALL load the FIFO head and pop it on an edge where FIFO non-empty and (state EMPTY, or state FULL with master_waitrequest low).
REQ-021 In FULL with master_waitrequest high, address, data and write SHALL hold stable.
REQ-022 In FULL with master_waitrequest low and FIFO empty, next state SHALL be EMPTY; with FIFO non-empty, state stays FULL with the next entry (back-to-back, no bubble).
REQ-023 wr_done SHALL be high exactly in the cycle after each edge where master_write=1 and master_waitrequest=0.
REQ-024 Latency: pixel accepted at edge N into empty block SHALL give master_write=1 in the cycle after edge N+1; no FIFO bypass.
REQ-025 Full FIFO with simultaneous pop: pix_ready SHALL remain low that cycle (registered count, no push-on-pop).
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-027 idle SHALL equal FIFO empty AND state EMPTY.
REQ-028 In EMPTY, master_address and master_writedata SHALL be zero.

Reset
REQ-029 Reset SHALL asynchronously force state EMPTY, FIFO empty, master_write=0, master_address=0, master_writedata=0, wr_done=0, pix_ready=1 after release, idle=1.
REQ-030 Reset mid-write SHALL drop master_write immediately and discard all queued pixels; no wr_done for the aborted write.

Configuration
REQ-031 With PIXEL_WRITE_MASTER_PERF_EN defined, the block SHALL add input perf_clr (1) and outputs perf_writes (32) and perf_stalls (32).
REQ-032 perf_writes SHALL increment per completed write, perf_stalls per cycle with master_write and master_waitrequest high; both wrap at 2^32, zero on reset, synchronous clear on perf_clr (clear wins over increment).
REQ-033 Without the macro, the ports and counters SHALL not exist and behaviour otherwise is identical.

Structure
REQ-034 Package pixel_write_master_pkg SHALL hold the output-state enum (OUT_EMPTY, OUT_FULL) and the legal-DATA_W check constant.
REQ-035 FIFO SHALL be a sub-module pwm_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head).

Verification
REQ-036 Single pixel addr=0x0800_0010, color=0xF800, waitrequest=0 -> one write cycle with those values, wr_done pulse next cycle, idle returns 1.
REQ-037 Waitrequest held 5 cycles on first write -> address/data stable 6 cycles, exactly one wr_done.
REQ-038 Burst of 8 pixels, DEPTH=8, waitrequest=0 -> 8 consecutive write cycles, in order, no gap.
REQ-039 Waitrequest stuck high, push 9 pixels -> pix_ready low after 9th acceptance attempt fills FIFO (8 queued + 1 in output); extra pixel held until release.
REQ-040 Reset asserted during stalled write with 3 queued -> master_write 0 immediately; after release no writes issued, idle=1.
REQ-041 DATA_W=32 with PIXEL_WRITE_MASTER_PERF_EN, 4 writes each stalled 2 cycles -> byteenable 4'b1111, perf_writes=4, perf_stalls=8; perf_clr -> both 0.

Source files
------------

// File: rtl/pixel_write_master_pkg.sv
// Shared types and constants for the pixel write master.
package pixel_write_master_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  localparam int DATA_W_NARROW = 16;
  localparam int DATA_W_WIDE   = 32;

  function automatic bit data_w_legal(input int w);
    return (w == DATA_W_NARROW) || (w == DATA_W_WIDE);
  endfunction

endpackage

// File: rtl/pwm_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and first-word-fall-through head.
module pwm_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head is read combinationally so the consumer can load it the edge after a push.
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_master.sv
// Pixel write master: queues drawing-engine pixels and issues them as Avalon-MM writes.
// Define PIXEL_WRITE_MASTER_PERF_EN to add write/stall performance counters.
module pixel_write_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_valid,
  input  logic [ADDR_W-1:0]   pix_addr,
  input  logic [DATA_W-1:0]   pix_color,
  output logic                pix_ready,
  output logic                wr_done,
  output logic                idle,
`ifdef PIXEL_WRITE_MASTER_PERF_EN
  input  logic                perf_clr,
  output logic [31:0]         perf_writes,
  output logic [31:0]         perf_stalls,
`endif
  input  logic                master_waitrequest,
  output logic [ADDR_W-1:0]   master_address,
  output logic                master_write,
  output logic [DATA_W-1:0]   master_writedata,
  output logic [DATA_W/8-1:0] master_byteenable
);
  import pixel_write_master_pkg::*;

  localparam int ENTRY_W = ADDR_W + DATA_W;

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("pixel_write_master: DATA_W must be 16 or 32");
  end

  out_state_e          state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                done_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                write_done;

  pwm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pix_valid),
    .din_i   ({pix_addr, pix_color}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign write_done = (state_q == OUT_FULL) && !master_waitrequest;
  assign fifo_pop   = !fifo_empty && ((state_q == OUT_EMPTY) || !master_waitrequest);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= write_done;
      if (fifo_pop) begin
        // Covers both the first load and back-to-back refill after an accepted write.
        state_q <= OUT_FULL;
        {addr_q, data_q} <= fifo_head;
      end else if (write_done) begin
        state_q <= OUT_EMPTY;
        addr_q  <= '0;
        data_q  <= '0;
      end
    end
  end

  assign pix_ready        = !fifo_full;
  assign wr_done          = done_q;
  assign idle             = fifo_empty && (state_q == OUT_EMPTY);
  assign master_write     = (state_q == OUT_FULL);
  assign master_address   = addr_q;
  assign master_writedata = data_q;

  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_byteenable
    assign master_byteenable[gi] = 1'b1;
  end

`ifdef PIXEL_WRITE_MASTER_PERF_EN
  logic [31:0] perf_writes_q;
  logic [31:0] perf_writes_d;
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_stalls_d;

  always_comb begin
    perf_writes_d = perf_writes_q;
    perf_stalls_d = perf_stalls_q;
    if (perf_clr) begin
      perf_writes_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (write_done) perf_writes_d = perf_writes_q + 32'd1;
      if (master_write && master_waitrequest) perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_writes_q <= perf_writes_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_writes = perf_writes_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
